mccoy_sequencer: RTL

- Multi-cycle control sequencer for the McCoy datapath.
- Owns the PC and the instruction register (IR), and fetches instructions from external instruction memory via a req/ack handshake.
- Feeds IR opcode to the opcode decoder and consumes its bez/ja/writeReg/writex8 outputs.
- Issues single-cycle write strobes and PC updates, one instruction at a time.

---
 rtl/mccoy_sequencer.sv | 133 +++++++++++++
 1 files changed

// File: rtl/mccoy_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer for the McCoy datapath.
// Define SEQ_TIMEOUT_EN to bound the fetch wait with a TIMEOUT-cycle watchdog that raises fault.
module mccoy_sequencer #(
  parameter int PC_W    = 5,
  parameter int TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  output logic            mem_req,
  output logic [PC_W-1:0] mem_addr,
  input  logic            mem_ack,
  input  logic [7:0]      mem_rdata,
  output logic [2:0]      opcode,
  output logic [4:0]      operand,
  input  logic            bez,
  input  logic            ja,
  input  logic            writeReg,
  input  logic            writex8,
  input  logic            x8_zero,
  output logic            reg_we,
  output logic            x8_we,
  output logic [PC_W-1:0] pc,
  output logic            halted,
  output logic            fault
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_HALT   = 3'd4;

  logic [2:0]      state;
  logic [7:0]      ir;
  logic [PC_W-1:0] target;

  assign opcode   = ir[7:5];
  assign operand  = ir[4:0];
  assign mem_addr = pc;

  // Branch/jump target: operand truncated or zero-extended to the PC width.
  assign target = PC_W'(ir[4:0]);

`ifdef SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] tcount;
`else
  assign fault = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      pc      <= '0;
      ir      <= '0;
      mem_req <= 1'b0;
      reg_we  <= 1'b0;
      x8_we   <= 1'b0;
      halted  <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
      fault   <= 1'b0;
      tcount  <= '0;
`endif
    end else begin
      // Strobes default low so each one lasts exactly the EXEC cycle.
      reg_we <= 1'b0;
      x8_we  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (run) begin
            state   <= S_FETCH;
            mem_req <= 1'b1;
`ifdef SEQ_TIMEOUT_EN
            tcount  <= '0;
`endif
          end
        end
        S_FETCH: begin
          if (mem_req && mem_ack) begin
            ir      <= mem_rdata;
            mem_req <= 1'b0;
            state   <= S_DECODE;
          end
`ifdef SEQ_TIMEOUT_EN
          else if (tcount == CNT_W'(TIMEOUT - 1)) begin
            mem_req <= 1'b0;
            fault   <= 1'b1;
            halted  <= 1'b1;
            state   <= S_HALT;
          end else begin
            tcount <= tcount + 1'b1;
          end
`endif
        end
        S_DECODE: begin
          // Decoder outputs have settled on the stable IR; latch them as EXEC strobes.
          if (ir[7:5] == 3'b111) begin
            state  <= S_HALT;
            halted <= 1'b1;
          end else begin
            state  <= S_EXEC;
            reg_we <= writeReg;
            x8_we  <= writex8;
          end
        end
        S_EXEC: begin
          if (ja)
            pc <= target;
          else if (bez && x8_zero)
            pc <= target;
          else
            pc <= pc + 1'b1;
          if (run) begin
            state   <= S_FETCH;
            mem_req <= 1'b1;
`ifdef SEQ_TIMEOUT_EN
            tcount  <= '0;
`endif
          end else begin
            state <= S_IDLE;
          end
        end
        S_HALT: begin
          halted  <= 1'b1;
          mem_req <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
